// File: rtl/mem_pkg.sv
// Shared types, widths and address-checking helper for the data-memory responder.
package mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Word-aligned and inside the array; the widened compare cannot overflow for any depth.
    function automatic logic addr_valid(input logic [ADDR_W-1:0] addr, input int unsigned depth);
        logic [ADDR_W+1:0] limit;
        limit = (ADDR_W+2)'(depth) * (ADDR_W+2)'(WORD_BYTES);
        return (addr[1:0] == 2'b00) && ({2'b00, addr} < limit);
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage for the responder: one synchronous write port and one registered read port.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX         = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              i_we,
    input  logic [IDX-1:0]    i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic              i_rclr,
    input  logic [IDX-1:0]    i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: clearing the whole array on reset forces it into flops; the contents must read back as zero after reset.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_rdata <= '0;
        end else if (i_rclr) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-stage responder: accepts one request, waits WAIT_STATES cycles, then answers with Ready for one cycle.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic        EnableReadFromMemory,
    input  logic        EnableWriteInMemory,
    input  logic [31:0] address,
    input  logic [31:0] InputData,
    output logic [31:0] OutputData,
    output logic        Ready,
    output logic        Stall,
    output logic        Error
);

    localparam int         IDX      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_is_write;
    logic                r_ready;
    logic                r_error;

    logic                w_req;
    logic                w_accept;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_c_addr;
    logic [DATA_W-1:0]   w_c_data;
    logic                w_c_write;
    logic                w_valid;
    logic [DATA_W-1:0]   w_rdata;

    assign w_req    = EnableReadFromMemory | EnableWriteInMemory;
    assign w_accept = (r_state == IDLE) && w_req;
    assign w_commit = (w_accept && (WAIT_STATES == 0)) || ((r_state == WAIT) && (r_cnt == 4'd0));

    // With zero wait states the commit edge is the accept edge, so the live request is used directly.
    assign w_c_addr  = (r_state == IDLE) ? address             : r_addr;
    assign w_c_data  = (r_state == IDLE) ? InputData           : r_data;
    assign w_c_write = (r_state == IDLE) ? EnableWriteInMemory : r_is_write;
    assign w_valid   = addr_valid(w_c_addr, DEPTH_WORDS);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req) w_next_state = (WAIT_STATES == 0) ? RESP : WAIT;
            WAIT:    if (r_cnt == 4'd0) w_next_state = RESP;
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_data     <= '0;
            r_is_write <= 1'b0;
            r_ready    <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ready <= w_commit;
            r_error <= w_commit && !w_valid;
            if (w_accept) begin
                r_addr     <= address;
                r_data     <= InputData;
                r_is_write <= EnableWriteInMemory;
                r_cnt      <= CNT_LOAD;
            end else if ((r_state == WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX         (IDX)
    ) u_array (
        .clk     (clk),
        .Reset   (Reset),
        .i_we    (w_commit && w_c_write && w_valid),
        .i_waddr (w_c_addr[IDX+1:2]),
        .i_wdata (w_c_data),
        .i_re    (w_commit && !w_c_write && w_valid),
        .i_rclr  (w_commit && !w_c_write && !w_valid),
        .i_raddr (w_c_addr[IDX+1:2]),
        .o_rdata (w_rdata)
    );

    assign OutputData = w_rdata;
    assign Ready      = r_ready;
    assign Error      = r_error;
    assign Stall      = w_accept || (r_state == WAIT);

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench: two responders (2 wait states / 256 words, 0 wait states / 16 words) against a transaction-level model.
module tb_data_mem_responder;

    localparam int D0  = 256;
    localparam int D1  = 16;
    localparam int WS0 = 2;
    localparam int WS1 = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd   [2];
    logic        wr   [2];
    logic [31:0] addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        ready[2];
    logic        stall[2];
    logic        err  [2];

    logic [31:0] mem0 [D0];
    logic [31:0] mem1 [D1];
    logic [31:0] exp_out [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(D0), .WAIT_STATES(WS0)) dut (
        .clk(clk), .Reset(rst),
        .EnableReadFromMemory(rd[0]), .EnableWriteInMemory(wr[0]),
        .address(addr[0]), .InputData(din[0]),
        .OutputData(dout[0]), .Ready(ready[0]), .Stall(stall[0]), .Error(err[0])
    );

    data_mem_responder #(.DEPTH_WORDS(D1), .WAIT_STATES(WS1)) dut_ws0 (
        .clk(clk), .Reset(rst),
        .EnableReadFromMemory(rd[1]), .EnableWriteInMemory(wr[1]),
        .address(addr[1]), .InputData(din[1]),
        .OutputData(dout[1]), .Ready(ready[1]), .Stall(stall[1]), .Error(err[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_ok(input int sel, input logic [31:0] a);
        int depth;
        depth = (sel == 0) ? D0 : D1;
        return (a % 4 == 0) && ((a >> 2) < 32'(depth));
    endfunction

    task automatic clear_models();
        for (int i = 0; i < D0; i++) mem0[i] = '0;
        for (int i = 0; i < D1; i++) mem1[i] = '0;
        exp_out[0] = '0;
        exp_out[1] = '0;
    endtask

    // One complete request: drive, optionally scramble inputs while waiting, then check the response.
    task automatic txn(input int sel, input bit do_rd, input bit do_wr, input logic [31:0] a,
                       input logic [31:0] d, input bit wiggle, input string tag);
        int ws;
        int stall_cnt;
        bit got;
        bit ok;
        ws = (sel == 0) ? WS0 : WS1;
        ok = ref_ok(sel, a);
        if (do_wr) begin
            if (ok) begin
                if (sel == 0) mem0[a >> 2] = d;
                else          mem1[a >> 2] = d;
            end
        end else if (!ok) begin
            exp_out[sel] = '0;
        end else begin
            exp_out[sel] = (sel == 0) ? mem0[a >> 2] : mem1[a >> 2];
        end

        @(negedge clk);
        rd[sel] = do_rd; wr[sel] = do_wr; addr[sel] = a; din[sel] = d;
        got = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 32; c++) begin
            #1;
            if (ready[sel]) begin
                got = 1'b1;
                break;
            end
            if (stall[sel]) stall_cnt++;
            @(posedge clk);
            #1;
            if (wiggle) begin
                addr[sel] = $urandom;
                din[sel]  = $urandom;
            end
            @(negedge clk);
        end
        check({tag, "_ready"}, 32'(got), 32'd1);
        check({tag, "_stall_cycles"}, 32'(stall_cnt), 32'(ws + 1));
        check({tag, "_stall_in_resp"}, 32'(stall[sel]), 32'd0);
        check({tag, "_error"}, 32'(err[sel]), 32'(!ok));
        check({tag, "_data"}, dout[sel], exp_out[sel]);
        rd[sel] = 1'b0; wr[sel] = 1'b0;
        @(negedge clk);
        #1;
        check({tag, "_ready_one_cycle"}, 32'(ready[sel]), 32'd0);
        check({tag, "_error_cleared"}, 32'(err[sel]), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  kind;

        rst = 1'b1;
        for (int s = 0; s < 2; s++) begin
            rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; din[s] = '0;
        end
        clear_models();
        #12;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("reset_data%0d", s), dout[s], 32'd0);
            check($sformatf("reset_ready%0d", s), 32'(ready[s]), 32'd0);
            check($sformatf("reset_error%0d", s), 32'(err[s]), 32'd0);
            check($sformatf("reset_stall%0d", s), 32'(stall[s]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of a pending write: nothing commits, array cleared.
        txn(0, 0, 1, 32'h10, 32'h1111_2222, 0, "pre_rst_wr");
        @(negedge clk);
        wr[0] = 1'b1; addr[0] = 32'h10; din[0] = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check("rst_wait_stall", 32'(stall[0]), 32'd1);
        wr[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_wait_ready", 32'(ready[0]), 32'd0);
        check("rst_wait_error", 32'(err[0]), 32'd0);
        check("rst_wait_data", dout[0], 32'd0);
        check("rst_wait_stall_off", 32'(stall[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        clear_models();
        txn(0, 1, 0, 32'h10, 32'h0, 0, "rst_readback");

        txn(0, 0, 1, 32'h8, 32'hCAFE_F00D, 0, "wr_cafe");
        txn(0, 1, 0, 32'h8, 32'h0, 0, "rd_cafe");
        txn(0, 1, 1, 32'h0, 32'h1234_5678, 0, "both_en");
        txn(0, 1, 0, 32'h0, 32'h0, 0, "rd_both_en");

        txn(0, 1, 0, 32'h6, 32'h0, 0, "rd_misaligned");
        txn(0, 0, 1, 32'(4 * D0), 32'hFFFF_FFFF, 0, "wr_out_of_range");

        txn(0, 0, 1, 32'h20, 32'hA5A5_5A5A, 1, "wiggle_wr");
        txn(0, 1, 0, 32'h20, 32'h0, 1, "wiggle_rd");

        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'($urandom_range(0, D0 - 1)) * 4 + 32'($urandom_range(1, 3));
                1:       a = 32'($urandom_range(4 * D0, 8 * D0)) & ~32'd3;
                default: a = 32'($urandom_range(0, D0 - 1)) * 4;
            endcase
            kind = 2'($urandom_range(1, 3));
            txn(0, kind[0], kind[1], a, $urandom, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

        // Out-of-range write must have left every word as the model says.
        for (int w = 0; w < D0; w++) begin
            txn(0, 1, 0, 32'(w * 4), 32'h0, 0, $sformatf("scan%0d", w));
        end

        txn(1, 1, 0, 32'h4, 32'h0, 0, "ws0_rd_empty");
        txn(1, 0, 1, 32'h4, 32'h0BAD_F00D, 0, "ws0_wr");
        txn(1, 1, 0, 32'h4, 32'h0, 0, "ws0_rd");
        txn(1, 1, 0, 32'h42, 32'h0, 0, "ws0_misaligned");
        for (int n = 0; n < 16; n++) begin
            a = 32'($urandom_range(0, D1)) * 4;
            kind = 2'($urandom_range(1, 3));
            txn(1, kind[0], kind[1], a, $urandom, 0, $sformatf("ws0_rand%0d", n));
        end

        // Request held high with no wait states: accepted every second cycle.
        txn(1, 0, 1, 32'h4, 32'h0BAD_F00D, 0, "ws0_b2b_prep");
        exp_out[1] = mem1[1];
        @(negedge clk);
        rd[1] = 1'b1; addr[1] = 32'h4;
        for (int c = 0; c < 6; c++) begin
            #1;
            check($sformatf("b2b_ready%0d", c), 32'(ready[1]), 32'(c % 2));
            check($sformatf("b2b_stall%0d", c), 32'(stall[1]), 32'((c + 1) % 2));
            if (c % 2 == 1) check($sformatf("b2b_data%0d", c), dout[1], exp_out[1]);
            if (c == 5) rd[1] = 1'b0;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
